// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the rr_mux arbitrating multiplexer.
package rr_mux_pkg;

  // Arbitration policy: fixed lowest-index priority or rotating round-robin.
  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_e;

  // Width of a channel index. A single-channel mux still gets one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: one-hot grant plus its index.
// Round-robin scans upward from ptr with wrap at N-1; fixed mode scans from 0.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int        N    = 4,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int       SW   = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          any_grant
);

  // Pick the first requester in scan order; the wrap is done against N so a
  // non-power-of-two channel count never visits an index past N-1.
  always_comb begin : pick
    int idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the unassigned paths infer latches.
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (MODE == ARB_RR) ? int'(ptr) + k : k;
      if (idx >= N) idx = idx - N;
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = SW'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-channel WIDTH-bit arbitrating mux with a single registered output stage
// and valid/ready handshakes on both sides.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int        N     = 4,
  parameter int        WIDTH = 64,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SW    = sel_width(N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  input  logic [N-1:0]              in_valid,
  output logic [N-1:0]              in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SW-1:0]             out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SW-1:0] ptr;
  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          any_grant;
  logic          load_en;
  logic [SW-1:0] ptr_next;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // The output register can take a word when it is empty or being drained
  // this cycle; nothing is accepted while reset is held.
  assign load_en  = !reset && (!out_valid || out_ready);
  assign in_ready = load_en ? grant : '0;

  // Round-robin pointer moves just past the winner, wrapping at N-1.
  assign ptr_next = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);

  // Output stage and pointer: load on transfer, empty when idle, hold on stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= any_grant;
      if (any_grant) begin
        out_data <= in_data[grant_idx];
        out_sel  <= grant_idx;
        ptr      <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux: three instances (N=4 round-robin,
// N=4 fixed priority, N=3 round-robin) against a behavioural model.
module tb_rr_mux;
  import rr_mux_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        vld0, vld1;
  logic [2:0]        vld2;
  logic              rdy [3];
  logic [63:0]       dat [4];
  logic [3:0][63:0]  data4;
  logic [2:0][63:0]  data3;

  logic [3:0]  ir0, ir1;
  logic [2:0]  ir2;
  logic [63:0] od0, od1, od2;
  logic [1:0]  os0, os1, os2;
  logic        ov0, ov1, ov2;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  assign data4 = {dat[3], dat[2], dat[1], dat[0]};
  assign data3 = {dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  rr_mux #(.N(4), .WIDTH(64), .MODE(ARB_RR)) u_d0 (
    .clk(clk), .reset(reset), .in_data(data4), .in_valid(vld0), .in_ready(ir0),
    .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(rdy[0]));

  rr_mux #(.N(4), .WIDTH(64), .MODE(ARB_FIXED)) u_d1 (
    .clk(clk), .reset(reset), .in_data(data4), .in_valid(vld1), .in_ready(ir1),
    .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(rdy[1]));

  rr_mux #(.N(3), .WIDTH(64), .MODE(ARB_RR)) u_d2 (
    .clk(clk), .reset(reset), .in_data(data3), .in_valid(vld2), .in_ready(ir2),
    .out_data(od2), .out_sel(os2), .out_valid(ov2), .out_ready(rdy[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          n_ch  [3] = '{4, 4, 3};
  bit          is_rr [3] = '{1'b1, 1'b0, 1'b1};
  bit          mv    [3] = '{0, 0, 0};
  logic [63:0] md    [3] = '{64'h0, 64'h0, 64'h0};
  int          ms    [3] = '{0, 0, 0};
  int          mp    [3] = '{0, 0, 0};

  function automatic logic [3:0] vld_of(input int m);
    case (m)
      0:       return vld0;
      1:       return vld1;
      default: return {1'b0, vld2};
    endcase
  endfunction

  // Winner by the rules: first valid channel starting at ptr (RR) or 0 (fixed).
  function automatic int model_grant(input int m);
    logic [3:0] v;
    int start;
    v = vld_of(m);
    start = is_rr[m] ? mp[m] : 0;
    for (int k = 0; k < n_ch[m]; k++)
      if (v[(start + k) % n_ch[m]]) return (start + k) % n_ch[m];
    return -1;
  endfunction

  function automatic bit model_load(input int m);
    return !reset && (!mv[m] || rdy[m]);
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 3; m++) begin
      int g;
      bit ld;
      g  = model_grant(m);
      ld = model_load(m);
      if (reset) begin
        mv[m] = 0; md[m] = '0; ms[m] = 0; mp[m] = 0;
      end else if (ld) begin
        if (g >= 0) begin
          mv[m] = 1; md[m] = dat[g]; ms[m] = g; mp[m] = (g + 1) % n_ch[m];
        end else begin
          mv[m] = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 3; m++) begin
        int          g;
        logic [3:0]  exp_rdy;
        logic [3:0]  a_rdy;
        logic [63:0] a_data;
        int          a_sel;
        logic        a_valid;
        int          a_ptr;
        g = model_grant(m);
        exp_rdy = (model_load(m) && g >= 0) ? (4'b0001 << g) : 4'b0000;
        case (m)
          0:       begin a_rdy = ir0; a_data = od0; a_sel = int'(os0); a_valid = ov0; a_ptr = int'(u_d0.ptr); end
          1:       begin a_rdy = ir1; a_data = od1; a_sel = int'(os1); a_valid = ov1; a_ptr = 0; end
          default: begin a_rdy = {1'b0, ir2}; a_data = od2; a_sel = int'(os2); a_valid = ov2; a_ptr = int'(u_d2.ptr); end
        endcase
        check($sformatf("d%0d in_ready", m), 64'(a_rdy), 64'(exp_rdy));
        check($sformatf("d%0d out_valid", m), 64'(a_valid), 64'(mv[m]));
        if (mv[m]) begin
          check($sformatf("d%0d out_data", m), a_data, md[m]);
          check($sformatf("d%0d out_sel", m), 64'(a_sel), 64'(ms[m]));
        end
        if (is_rr[m]) check($sformatf("d%0d ptr", m), 64'(a_ptr), 64'(mp[m]));
      end
    end
  end

  // Advance one cycle; returns just after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    reset = 1'b1;
    vld0 = 4'b1111; vld1 = 4'b1100; vld2 = 3'b111;
    for (int i = 0; i < 3; i++) rdy[i] = 1'b1;
    for (int i = 0; i < 4; i++) dat[i] = 64'(i * 'h11);

    // Reset held two cycles with every channel requesting.
    tick();
    chk_en = 1'b1;
    check("reset in_ready", 64'(ir0), 64'h0);
    check("reset out_valid", 64'(ov0), 64'h0);
    check("reset out_data", od0, 64'h0);
    check("reset out_sel", 64'(os0), 64'h0);
    tick();
    reset = 1'b0;

    // Rotation: d0 0,1,2,3,0; d1 fixed stays on 2; d2 0,1,2,0,1.
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rr4 sel", 64'(os0), 64'(c % 4));
      check("rr4 data", od0, 64'((c % 4) * 'h11));
      check("fixed sel", 64'(os1), 64'h2);
      check("rr3 sel", 64'(os2), 64'(c % 3));
    end

    // Reset with a word held.
    check("pre-reset valid", 64'(ov0), 64'h1);
    reset = 1'b1;
    tick();
    check("mid reset valid", 64'(ov0), 64'h0);
    check("mid reset ptr", 64'(u_d0.ptr), 64'h0);
    check("mid reset rr3 valid", 64'(ov2), 64'h0);
    reset = 1'b0;
    vld0  = 4'b1010;

    // Sparse wrap: grants 1,3,1,3 with ptr 2,0,2,0.
    for (int c = 0; c < 4; c++) begin
      tick();
      check("sparse sel", 64'(os0), (c % 2) ? 64'h3 : 64'h1);
      check("sparse ptr", 64'(u_d0.ptr), (c % 2) ? 64'h0 : 64'h2);
    end

    // Load words 0,1,2 then stall with 'h22 held.
    vld0 = 4'b1111;
    for (int c = 0; c < 3; c++) tick();
    check("pre-stall sel", 64'(os0), 64'h2);
    rdy[0] = 1'b0;
    dat[2] = 64'hAA;
    vld1   = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall data", od0, 64'h22);
      check("stall sel", 64'(os0), 64'h2);
      check("stall in_ready", 64'(ir0), 64'h0);
      check("stall ptr", 64'(u_d0.ptr), 64'h3);
    end
    rdy[0] = 1'b1;
    dat[2] = 64'h22;
    tick();
    check("post-stall sel", 64'(os0), 64'h3);
    check("post-stall data", od0, 64'h33);
    check("fixed after drop", 64'(os1), 64'h3);

    // Idle: nothing valid empties the output register.
    vld0 = 4'b0000;
    tick();
    check("idle valid", 64'(ov0), 64'h0);

    // Mixed traffic with backpressure; the model checks every cycle.
    for (int c = 0; c < 80; c++) begin
      vld0 = 4'($urandom);
      vld1 = 4'($urandom);
      vld2 = 3'($urandom);
      for (int i = 0; i < 3; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) dat[i] = {$urandom, $urandom};
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
